// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lfsr_pkg
//  Purpose : Shared definitions for the shared-LFSR controller: datapath
//            width, feedback tap positions, controller FSM states and the
//            single-step LFSR next-state function.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  localparam int LFSR_W = 16;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bit positions in s).
  localparam int TAP_0 = 15;
  localparam int TAP_1 = 13;
  localparam int TAP_2 = 12;
  localparam int TAP_3 = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    PRESENT = 2'd2
  } fsm_e;

  // Fibonacci step: shift left and insert the XOR of the taps at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_step_reg.sv
`default_nettype none
// ============================================================================
//  Module  : lfsr_step_reg
//  Purpose : 16-bit LFSR state register. A load takes priority over a step;
//            loading all-zeros substitutes ZERO_SUB so the LFSR can never
//            reach its lock-up state.
//  Ports   : clk      - rising-edge clock
//            reset    - asynchronous active-high reset (state <= RESET_SEED)
//            load     - load load_val (zero-guarded)
//            load_val - value to load
//            en       - advance the LFSR by one step
//            state    - current LFSR state
//  Revision: 1.0 - initial release
// ============================================================================
module lfsr_step_reg
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = 16'd13,
  parameter logic [LFSR_W-1:0] ZERO_SUB   = 16'h0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_SEED;
    end else if (load) begin
      state <= (load_val == '0) ? ZERO_SUB : load_val;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : lfsr_share_ctrl
//  Purpose : Shares one 16-bit LFSR between NREQ requesters. A round-robin
//            arbiter picks a requester, the LFSR is advanced STEPS times and
//            the resulting word is presented over a valid/ready handshake.
//  Ports   : clk       - rising-edge clock
//            reset     - asynchronous active-high reset
//            seed_load - pulse: load seed_in into the LFSR (zero-guarded)
//            seed_in   - seed value
//            req       - level request per requester, held until served
//            rnd_gnt   - one-hot owner of the current transaction, 0 if idle
//            rnd_out   - delivered word, stable while rnd_valid
//            rnd_valid - rnd_out valid for the rnd_gnt owner
//            rnd_ready - consumer accept
//            busy      - transaction in progress (STEP or PRESENT)
//            state     - current LFSR state (monitor)
//  Revision: 1.0 - initial release
// ============================================================================
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int                NREQ       = 2,
  parameter int                STEPS      = 16,
  parameter logic [LFSR_W-1:0] RESET_SEED = 16'd13,
  parameter logic [LFSR_W-1:0] ZERO_SUB   = 16'h0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   rnd_gnt,
  output logic [LFSR_W-1:0] rnd_out,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy,
  output logic [LFSR_W-1:0] state
);

  localparam int         C_IDX_W = $clog2(NREQ);
  localparam logic [7:0] C_LAST  = 8'(STEPS - 1);

  fsm_e               r_fsm;
  fsm_e               w_fsm_nxt;
  logic [C_IDX_W-1:0] r_rr;
  logic [C_IDX_W-1:0] r_gnt_idx;
  logic [C_IDX_W-1:0] w_pick;
  logic [7:0]         r_cnt;
  logic               w_grant;
  logic               w_step;
  logic               w_cap;
  logic               w_done;
  logic [LFSR_W-1:0]  w_lfsr_nxt;

  lfsr_step_reg #(
    .RESET_SEED (RESET_SEED),
    .ZERO_SUB   (ZERO_SUB)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_in),
    .en       (w_step),
    .state    (state)
  );

  assign w_lfsr_nxt = lfsr_next(state);
  assign busy       = (r_fsm != IDLE);

  // Round-robin pick: scan from the highest offset down so that the set bit
  // closest to (at or after) the pointer is the last one written.
  always_comb begin
    w_pick = r_rr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[C_IDX_W'((int'(r_rr) + i) % NREQ)]) begin
        w_pick = C_IDX_W'((int'(r_rr) + i) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // seed_load in STEP suppresses the step for that cycle (the register loads
  // instead) and restarts the count, so the word is STEPS steps of the seed.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_grant   = 1'b0;
    w_step    = 1'b0;
    w_cap     = 1'b0;
    w_done    = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (|req) begin
          w_grant   = 1'b1;
          w_fsm_nxt = STEP;
        end
      end
      STEP: begin
        if (!seed_load) begin
          w_step = 1'b1;
          if (r_cnt == C_LAST) begin
            w_cap     = 1'b1;
            w_fsm_nxt = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (rnd_valid && rnd_ready) begin
          w_done    = 1'b1;
          w_fsm_nxt = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd_gnt   <= '0;
      rnd_out   <= '0;
      rnd_valid <= 1'b0;
      r_rr      <= '0;
      r_gnt_idx <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_grant) begin
        rnd_gnt   <= NREQ'(1) << w_pick;
        r_gnt_idx <= w_pick;
        r_cnt     <= '0;
      end
      if (r_fsm == STEP && seed_load) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_cap) begin
        rnd_out   <= w_lfsr_nxt;
        rnd_valid <= 1'b1;
      end
      if (w_done) begin
        rnd_valid <= 1'b0;
        rnd_gnt   <= '0;
        r_rr      <= (int'(r_gnt_idx) == NREQ - 1) ? '0 : r_gnt_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_lfsr_share_ctrl
//  Purpose : Self-checking bench for lfsr_share_ctrl. A STEPS=16 instance gets
//            randomized transactions checked against a transaction-level
//            model; a STEPS=1 instance checks known single-step words.
//  Ports   : none
//  Revision: 1.0 - initial release
// ============================================================================
module tb_lfsr_share_ctrl;

  localparam int STEPS = 16;

  logic        clk = 1'b0;
  logic        reset;

  logic        seed_load, rnd_ready, rnd_valid, busy;
  logic [15:0] seed_in, rnd_out, state;
  logic [1:0]  req, rnd_gnt;

  logic        s1_seed_load, s1_ready, s1_valid, s1_busy;
  logic [15:0] s1_seed_in, s1_out, s1_state;
  logic [1:0]  s1_req, s1_gnt;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_state = 16'd13;
  logic [15:0] m_out   = 16'h0000;
  int          m_rr    = 0;

  always #5 clk = ~clk;

  lfsr_share_ctrl #(.NREQ(2), .STEPS(STEPS)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .rnd_gnt(rnd_gnt), .rnd_out(rnd_out), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .busy(busy), .state(state)
  );

  lfsr_share_ctrl #(.NREQ(2), .STEPS(1)) dut1 (
    .clk(clk), .reset(reset), .seed_load(s1_seed_load), .seed_in(s1_seed_in),
    .req(s1_req), .rnd_gnt(s1_gnt), .rnd_out(s1_out), .rnd_valid(s1_valid),
    .rnd_ready(s1_ready), .busy(s1_busy), .state(s1_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: n applications of the polynomial, feedback = parity of taps.
  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = {v[14:0], ^(v & 16'hB400)};
    return v;
  endfunction

  function automatic logic [15:0] guard(input logic [15:0] s);
    return (s == 16'h0) ? 16'h0001 : s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input logic [15:0] s);
    seed_in = s; seed_load = 1'b1;
    tick;
    seed_load = 1'b0;
    m_state = guard(s);
    check("idle_load_state", state, m_state);
    check("idle_load_out", rnd_out, m_out);
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic run_txn(input logic [1:0] rq, input bit drop, input int mid_at,
                         input logic [15:0] mid_seed, input int hold);
    int          exp_i;
    int          c;
    logic [1:0]  exp_g;
    logic [15:0] base, word;
    exp_i = -1;
    for (int k = 1; k >= 0; k--) if (rq[(m_rr + k) % 2]) exp_i = (m_rr + k) % 2;
    exp_g = (exp_i == 0) ? 2'b01 : 2'b10;
    req = rq;
    tick;
    check("grant", rnd_gnt, exp_g);
    check("busy_step", busy, 1'b1);
    if (drop) req = 2'b00;
    base = m_state;
    c = 0;
    if (mid_at > 0) begin
      repeat (mid_at) begin
        tick; c++;
        check("step_state", state, adv(base, c));
      end
      seed_in = mid_seed; seed_load = 1'b1;
      tick;
      seed_load = 1'b0;
      base = guard(mid_seed);
      c = 0;
      check("midload_state", state, base);
    end
    while (!rnd_valid && c < 40) begin
      tick; c++;
      if (c <= STEPS) check("step_state", state, adv(base, c));
    end
    check("latency", c, STEPS);
    word = adv(base, STEPS);
    check("word", rnd_out, word);
    check("word_gnt", rnd_gnt, exp_g);
    repeat (hold) begin
      tick;
      check("hold_out", rnd_out, word);
      check("hold_gnt", rnd_gnt, exp_g);
      check("hold_state", state, word);
    end
    rnd_ready = 1'b1; req = 2'b00;
    tick;
    rnd_ready = 1'b0;
    check("done_valid", rnd_valid, 1'b0);
    check("done_gnt", rnd_gnt, 2'b00);
    check("done_busy", busy, 1'b0);
    m_state = word;
    m_out   = word;
    m_rr    = (exp_i + 1) % 2;
  endtask

  initial begin
    int          c;
    logic [15:0] s, ms;
    reset = 1'b1; seed_load = 0; seed_in = 0; req = 0; rnd_ready = 0;
    s1_seed_load = 0; s1_seed_in = 0; s1_req = 0; s1_ready = 0;
    tick; tick;
    reset = 1'b0;
    check("rst_state", state, 16'd13);
    check("rst_out", rnd_out, 16'h0);
    check("rst_valid", rnd_valid, 1'b0);
    check("rst_gnt", rnd_gnt, 2'b00);
    check("rst_busy", busy, 1'b0);

    // Both requesting, consumer always ready: grants alternate from 0.
    req = 2'b11; rnd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c = 0;
      while (!rnd_valid && c < 40) begin tick; c++; end
      check("rr_order", rnd_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      m_state = adv(m_state, STEPS);
      check("rr_word", rnd_out, m_state);
      tick;
    end
    req = 2'b00; rnd_ready = 1'b0; m_out = m_state; m_rr = 0;
    tick;
    check("rr_idle_busy", busy, 1'b0);

    // Single-step instance: known words.
    s1_seed_in = 16'hACE1; s1_seed_load = 1'b1; tick; s1_seed_load = 1'b0;
    check("s1_seed", s1_state, 16'hACE1);
    s1_req = 2'b01; tick;
    check("s1_gnt", s1_gnt, 2'b01);
    check("s1_valid_early", s1_valid, 1'b0);
    tick;
    check("s1_valid", s1_valid, 1'b1);
    check("s1_word_ace1", s1_out, 16'h59C3);
    s1_ready = 1'b1; s1_req = 2'b00; tick; s1_ready = 1'b0;
    check("s1_done", s1_valid, 1'b0);
    s1_seed_in = 16'h8000; s1_seed_load = 1'b1; tick; s1_seed_load = 1'b0;
    s1_req = 2'b01; tick; tick;
    check("s1_word_8000", s1_out, 16'h0001);
    s1_ready = 1'b1; s1_req = 2'b00; tick; s1_ready = 1'b0;

    // Zero seed is replaced and the sequence keeps running.
    load_idle(16'h0000);
    check("zero_guard", state, 16'h0001);
    run_txn(2'b01, 1'b0, 0, 16'h0, 0);
    run_txn(2'b10, 1'b0, 0, 16'h0, 5);

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        load_idle(s);
      end
      ms = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, STEPS - 2)) : 0,
              ms, int'($urandom_range(0, 5)));
    end

    // Asynchronous reset in the middle of STEP.
    req = 2'b10; tick; req = 2'b00;
    repeat (5) tick;
    reset = 1'b1;
    #1;
    check("amid_state", state, 16'd13);
    check("amid_busy", busy, 1'b0);
    check("amid_gnt", rnd_gnt, 2'b00);
    tick; tick;
    reset = 1'b0;
    check("amid_out", rnd_out, 16'h0);
    check("amid_valid", rnd_valid, 1'b0);
    req = 2'b11; tick; req = 2'b00;
    check("amid_rr_reset", rnd_gnt, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
